// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen
//   AXI4-Stream video test-pattern source. Emits V_ACTIVE lines of H_ACTIVE
//   pixels per frame. tuser marks the first pixel of a frame and tlast the
//   last pixel of a line. H_GAP idle cycles separate lines and V_GAP idle
//   cycles follow each frame. A run lasts num_frames frames, or runs until
//   enable drops when num_frames is 0. mode and num_frames are sampled at
//   every frame start.
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   enable               run request (level), sampled at frame boundaries
//   mode                 0 x ramp, 1 y ramp, 2 8x8 checkerboard, 3 tagged counter
//   num_frames           frames per run, 0 = free-running
//   m_axis_video_*       AXI4-Stream master (tdata/tvalid/tready/tlast/tuser)
//   busy                 high whenever not idle
//   frame_cnt            frames completed since reset (wrapping)
//   done                 one-cycle pulse on return to idle
module axis_pattern_gen #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_GAP    = 1750,
  parameter int unsigned V_GAP    = 1000,
  parameter int unsigned GAP_W    = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [15:0]       num_frames,
  output logic [DATA_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  input  logic              m_axis_video_tready,
  output logic              m_axis_video_tlast,
  output logic              m_axis_video_tuser,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HGAP, VGAP} state_t;

  localparam logic [11:0]      X_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0]      Y_LAST = 12'(V_ACTIVE - 1);
  localparam logic [GAP_W-1:0] H_LOAD = GAP_W'((H_GAP > 0) ? H_GAP - 1 : 0);
  localparam logic [GAP_W-1:0] V_LOAD = GAP_W'((V_GAP > 0) ? V_GAP - 1 : 0);

  state_t             state, state_d;
  logic [11:0]        x, x_d, y, y_d;
  logic [1:0]         mode_q, mode_d;
  logic [15:0]        nf_q, nf_d;
  logic [15:0]        run_cnt, run_d;
  logic [GAP_W-1:0]   gap_cnt, gap_d;
  logic [15:0]        fc_d;
  logic [DATA_W-1:0]  tdata_d;
  logic               tvalid_d, tlast_d, tuser_d, done_d;

  logic               load_beat, blank, eval_exit;
  logic [11:0]        bx, by;
  logic [1:0]         bmode;
  logic [15:0]        bfc, eval_run, eval_fc;

  function automatic logic [DATA_W-1:0] pixel(input logic [1:0]  m,
                                              input logic [11:0] px,
                                              input logic [11:0] py,
                                              input logic [15:0] fc);
    logic [31:0] tag;
    tag   = {fc[7:0], py, px};
    pixel = '0;
    case (m)
      2'd0:    pixel = DATA_W'(px);
      2'd1:    pixel = DATA_W'(py);
      2'd2:    pixel = (px[3] ^ py[3]) ? '1 : '0;
      default: pixel = DATA_W'(tag);
    endcase
  endfunction

  always_comb begin
    busy = (state != IDLE);
  end

  always_comb begin
    state_d   = state;
    x_d       = x;
    y_d       = y;
    mode_d    = mode_q;
    nf_d      = nf_q;
    run_d     = run_cnt;
    gap_d     = gap_cnt;
    fc_d      = frame_cnt;
    tdata_d   = m_axis_video_tdata;
    tvalid_d  = m_axis_video_tvalid;
    tlast_d   = m_axis_video_tlast;
    tuser_d   = m_axis_video_tuser;
    done_d    = 1'b0;
    load_beat = 1'b0;
    blank     = 1'b0;
    eval_exit = 1'b0;
    bx        = x;
    by        = y;
    bmode     = mode_q;
    bfc       = frame_cnt;
    eval_run  = run_cnt;
    eval_fc   = frame_cnt;

    case (state)
      IDLE: begin
        if (enable) begin
          state_d   = ACTIVE;
          mode_d    = mode;
          nf_d      = num_frames;
          run_d     = '0;
          x_d       = '0;
          y_d       = '0;
          load_beat = 1'b1;
          bx        = '0;
          by        = '0;
          bmode     = mode;
        end
      end
      ACTIVE: begin
        // Without a transfer all defaults hold, which keeps the beat stable.
        if (m_axis_video_tready) begin
          if (x != X_LAST) begin
            x_d       = x + 12'd1;
            load_beat = 1'b1;
            bx        = x + 12'd1;
          end else begin
            x_d = '0;
            if (y != Y_LAST) begin
              y_d = y + 12'd1;
              if (H_GAP == 0) begin
                load_beat = 1'b1;
                bx        = '0;
                by        = y + 12'd1;
              end else begin
                state_d = HGAP;
                gap_d   = H_LOAD;
                blank   = 1'b1;
              end
            end else begin
              y_d   = '0;
              run_d = run_cnt + 16'd1;
              fc_d  = frame_cnt + 16'd1;
              if (V_GAP == 0) begin
                // No vertical gap: decide the next frame now, using the
                // counts as they will be after this frame completes.
                eval_exit = 1'b1;
                eval_run  = run_cnt + 16'd1;
                eval_fc   = frame_cnt + 16'd1;
              end else begin
                state_d = VGAP;
                gap_d   = V_LOAD;
                blank   = 1'b1;
              end
            end
          end
        end
      end
      HGAP: begin
        if (gap_cnt == '0) begin
          state_d   = ACTIVE;
          load_beat = 1'b1;
        end else begin
          gap_d = gap_cnt - 1'b1;
        end
      end
      VGAP: begin
        if (gap_cnt == '0) begin
          eval_exit = 1'b1;
        end else begin
          gap_d = gap_cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (eval_exit) begin
      if (enable && (nf_q == '0 || eval_run < nf_q)) begin
        state_d   = ACTIVE;
        mode_d    = mode;
        nf_d      = num_frames;
        load_beat = 1'b1;
        bx        = '0;
        by        = '0;
        bmode     = mode;
        bfc       = eval_fc;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
        blank   = 1'b1;
      end
    end

    if (blank) begin
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
    end
    if (load_beat) begin
      tvalid_d = 1'b1;
      tdata_d  = pixel(bmode, bx, by, bfc);
      tlast_d  = (bx == X_LAST);
      tuser_d  = (bx == '0) && (by == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      x                   <= '0;
      y                   <= '0;
      mode_q              <= '0;
      nf_q                <= '0;
      run_cnt             <= '0;
      gap_cnt             <= '0;
      frame_cnt           <= '0;
      m_axis_video_tdata  <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
      m_axis_video_tuser  <= 1'b0;
      done                <= 1'b0;
    end else begin
      state               <= state_d;
      x                   <= x_d;
      y                   <= y_d;
      mode_q              <= mode_d;
      nf_q                <= nf_d;
      run_cnt             <= run_d;
      gap_cnt             <= gap_d;
      frame_cnt           <= fc_d;
      m_axis_video_tdata  <= tdata_d;
      m_axis_video_tvalid <= tvalid_d;
      m_axis_video_tlast  <= tlast_d;
      m_axis_video_tuser  <= tuser_d;
      done                <= done_d;
    end
  end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb_axis_pattern_gen
//   Directed bench for axis_pattern_gen. Instance "dut" uses line/frame gaps
//   of 2/5 cycles; instance "dut0" uses zero gaps for back-to-back streaming.
//   Expected beats come from a frame-level model pushed into queues; a single
//   negedge process compares every transfer, gap length, stall hold and done.
module tb_axis_pattern_gen;

  localparam int HA = 4;
  localparam int VA = 3;
  localparam int HG = 2;
  localparam int VG = 5;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
    int          gap;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, rdy_a, en_b, rdy_b;
  logic [1:0]  mode_a, mode_b;
  logic [15:0] nf_a, nf_b;
  logic [31:0] a_tdata, b_tdata;
  logic        a_tvalid, a_tlast, a_tuser, a_busy, a_done;
  logic        b_tvalid, b_tlast, b_tuser, b_busy, b_done;
  logic [15:0] a_fc, b_fc;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t       qa[$];
  beat_t       qb[$];
  logic [31:0] obs[$];
  beat_t       ea, eb;
  int          a_idle = 0, a_dones = 0;
  bit          a_stall = 0;
  logic [33:0] a_held;
  int          b_beats = 0, b_total = 0, b_dones = 0;
  bit          b_run = 0;

  always #5 clk = ~clk;

  axis_pattern_gen #(
    .DATA_W(32), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_GAP(HG), .V_GAP(VG), .GAP_W(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(en_a), .mode(mode_a), .num_frames(nf_a),
    .m_axis_video_tdata(a_tdata), .m_axis_video_tvalid(a_tvalid),
    .m_axis_video_tready(rdy_a), .m_axis_video_tlast(a_tlast),
    .m_axis_video_tuser(a_tuser), .busy(a_busy), .frame_cnt(a_fc), .done(a_done)
  );

  axis_pattern_gen #(
    .DATA_W(32), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_GAP(0), .V_GAP(0), .GAP_W(8)
  ) dut0 (
    .clk(clk), .rst(rst), .enable(en_b), .mode(mode_b), .num_frames(nf_b),
    .m_axis_video_tdata(b_tdata), .m_axis_video_tvalid(b_tvalid),
    .m_axis_video_tready(rdy_b), .m_axis_video_tlast(b_tlast),
    .m_axis_video_tuser(b_tuser), .busy(b_busy), .frame_cnt(b_fc), .done(b_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel value from the pattern definitions, in plain arithmetic.
  function automatic logic [31:0] model_pix(input int m, input int x, input int y, input int fc);
    case (m)
      0:       return 32'(x);
      1:       return 32'(y);
      2:       return (((x / 8) + (y / 8)) % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
      default: return 32'(fc % 256) * 32'h0100_0000 + 32'(y) * 32'd4096 + 32'(x);
    endcase
  endfunction

  // gap = idle cycles expected before the beat (-1: first beat of a run).
  task automatic push_frame(input bit lane_b, input int m, input int fc, input bit first,
                            input int hgap, input int vgap);
    beat_t b;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        b.data = model_pix(m, x, y, fc);
        b.last = (x == HA - 1);
        b.user = (x == 0 && y == 0);
        b.gap  = (x != 0) ? 0 : (y != 0) ? hgap : (first ? -1 : vgap);
        if (lane_b) qb.push_back(b);
        else        qa.push_back(b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      a_stall = 0;
      a_idle  = 0;
    end else begin
      if (a_stall) begin
        chk("a_stall_tvalid", a_tvalid, 1);
        chk("a_stall_hold", {a_tdata, a_tlast, a_tuser}, a_held);
      end
      if (a_tvalid) begin
        if (rdy_a) begin
          if (qa.size() == 0) begin
            chk("a_unexpected_beat", a_tdata, 64'hDEAD);
          end else begin
            ea = qa.pop_front();
            chk("a_tdata", a_tdata, ea.data);
            chk("a_tlast", a_tlast, ea.last);
            chk("a_tuser", a_tuser, ea.user);
            if (ea.gap >= 0) chk("a_gap_len", a_idle, ea.gap);
          end
          obs.push_back(a_tdata);
          a_idle  = 0;
          a_stall = 0;
        end else begin
          a_stall = 1;
          a_held  = {a_tdata, a_tlast, a_tuser};
        end
      end else begin
        chk("a_idle_zero", {a_tdata, a_tlast, a_tuser}, 0);
        if (a_done) begin
          chk("a_done_delay", a_idle, VG);
          a_dones++;
        end
        a_idle++;
      end

      if (b_run) chk("b_tvalid_cont", b_tvalid, 1);
      if (b_tvalid && rdy_b) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_beat", b_tdata, 64'hDEAD);
        end else begin
          eb = qb.pop_front();
          chk("b_tdata", b_tdata, eb.data);
          chk("b_tlast", b_tlast, eb.last);
          chk("b_tuser", b_tuser, eb.user);
        end
        b_beats++;
      end
      b_run = (b_beats > 0) && (b_beats < b_total);
      if (b_done) b_dones++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    qa.delete();
    obs.delete();
    a_dones = 0;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_done_a(input int budget, input bit drop, input bit stall);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      if (stall) rdy_a = (i < 8) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      else       rdy_a = 1'b1;
      tick(1);
      if (a_done) begin
        got = 1;
        if (drop) en_a = 1'b0;
      end
    end
    rdy_a = 1'b1;
    chk("a_done_seen", got, 1);
  endtask

  task automatic wait_beats_a(input int n, input int budget);
    for (int i = 0; i < budget && obs.size() < n; i++) tick(1);
    chk("a_beats_reached", obs.size() >= n, 1);
  endtask

  task automatic chk_end_a(input string tag, input int fc, input int beats);
    tick(2);
    chk({tag, "_frame_cnt"}, a_fc, fc);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_done_count"}, a_dones, 1);
    chk({tag, "_queue_empty"}, qa.size(), 0);
    chk({tag, "_beats"}, obs.size(), beats);
  endtask

  initial begin
    bit got;
    rst = 1'b1; en_a = 0; mode_a = 0; nf_a = 0; rdy_a = 1;
    en_b = 0; mode_b = 0; nf_b = 0; rdy_b = 1;
    tick(2);
    chk("rst_tvalid", a_tvalid, 0);
    chk("rst_tdata", a_tdata, 0);
    chk("rst_tlast_tuser", {a_tlast, a_tuser}, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_frame_cnt", a_fc, 0);
    chk("rst_done", a_done, 0);
    rst = 1'b0;
    tick(1);

    // 1: single ramp frame, enable pulsed, tready held high
    a_dones = 0; obs.delete();
    mode_a = 0; nf_a = 1;
    push_frame(0, 0, 0, 1, HG, VG);
    en_a = 1; tick(1); en_a = 0;
    wait_done_a(200, 0, 0);
    chk_end_a("t1", 1, 12);
    chk("t1_beat3", obs[3], 32'd3);
    chk("t1_beat8", obs[8], 32'd0);

    // 2: same frame under backpressure
    a_dones = 0; obs.delete();
    push_frame(0, 0, 1, 1, HG, VG);
    en_a = 1; tick(1); en_a = 0;
    wait_done_a(400, 0, 1);
    chk_end_a("t2", 2, 12);

    // 3: tagged counter, two-frame run
    do_reset();
    mode_a = 3; nf_a = 2;
    push_frame(0, 3, 0, 1, HG, VG);
    push_frame(0, 3, 1, 0, HG, VG);
    en_a = 1;
    wait_done_a(400, 1, 0);
    chk_end_a("t3", 2, 24);
    chk("t3_first", obs[0], 32'h0000_0000);
    chk("t3_f0_last", obs[11], 32'h0000_2003);
    chk("t3_f1_first", obs[12], 32'h0100_0000);
    chk("t3_f1_last", obs[23], 32'h0100_2003);

    // 4: free-run, mode change mid-frame, enable drop mid-frame
    do_reset();
    mode_a = 0; nf_a = 0;
    push_frame(0, 0, 0, 1, HG, VG);
    push_frame(0, 2, 1, 0, HG, VG);
    en_a = 1;
    wait_beats_a(2, 50);
    mode_a = 2;
    wait_beats_a(14, 100);
    en_a = 0;
    wait_done_a(200, 0, 0);
    chk_end_a("t4", 2, 24);
    chk("t4_f0_beat5", obs[5], 32'd1);
    chk("t4_f1_beat5", obs[17], 32'd0);

    // 5: reset mid-line at x=2, y=1
    do_reset();
    mode_a = 0; nf_a = 1;
    push_frame(0, 0, 0, 1, HG, VG);
    en_a = 1;
    wait_beats_a(6, 100);
    chk("t5_pre_tdata", a_tdata, 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_tvalid", a_tvalid, 0);
    chk("t5_rst_tdata", a_tdata, 0);
    chk("t5_rst_tlast_tuser", {a_tlast, a_tuser}, 0);
    chk("t5_rst_busy_done", {a_busy, a_done}, 0);
    chk("t5_rst_frame_cnt", a_fc, 0);
    qa.delete(); obs.delete(); a_dones = 0;
    push_frame(0, 0, 0, 1, HG, VG);
    tick(1);
    rst = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick(1);
      got = a_tvalid;
    end
    chk("t5_restart_valid", got, 1);
    chk("t5_restart_tuser", a_tuser, 1);
    chk("t5_restart_tdata", a_tdata, 0);
    wait_done_a(200, 1, 0);
    chk_end_a("t5", 1, 12);

    // 6: zero gaps, free-running, three frames back to back
    b_total = 3 * HA * VA;
    push_frame(1, 0, 0, 1, 0, 0);
    push_frame(1, 0, 1, 0, 0, 0);
    push_frame(1, 0, 2, 0, 0, 0);
    mode_b = 0; nf_b = 0; rdy_b = 1;
    en_b = 1;
    for (int i = 0; i < 100 && b_beats < 26; i++) tick(1);
    chk("t6_beats_reached", b_beats >= 26, 1);
    en_b = 0;
    for (int i = 0; i < 100 && b_dones == 0; i++) tick(1);
    tick(2);
    chk("t6_done_count", b_dones, 1);
    chk("t6_frame_cnt", b_fc, 3);
    chk("t6_beats", b_beats, b_total);
    chk("t6_queue_empty", qb.size(), 0);
    chk("t6_busy", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
